// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_LIVE = 2'd1,
      RSP_HOLD = 2'd2
   } rsp_state_e;

   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_DATA   = 1'b1;

   localparam int RAM_ARB_ADDR_BITS = 12;
   localparam int RAM_ARB_ROM_WORDS = 2048;

endpackage

// File: rtl/ram_arb_rsp_slot.sv
// Per-port response tracker: presents RAM data the cycle after grant (0 for writes), holds it under
// backpressure. free_o tells the arbiter the slot can take a command this cycle.
module ram_arb_rsp_slot
   import ram_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        grant_i,
   input  logic        zero_i,
   input  logic        rsp_ready_i,
   input  logic [31:0] ram_rdata_i,
   output logic        free_o,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o
);

   rsp_state_e  state_q, state_d;
   logic        zero_q, zero_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] live_data;

   always_comb begin
      live_data   = zero_q ? 32'h0 : ram_rdata_i;
      rsp_valid_o = (state_q != RSP_IDLE);
      free_o      = (state_q == RSP_IDLE) || rsp_ready_i;
      rsp_data_o  = 32'h0;
      case (state_q)
         RSP_LIVE: rsp_data_o = live_data;
         RSP_HOLD: rsp_data_o = hold_q;
         default:  rsp_data_o = 32'h0;
      endcase
   end

   // A grant can only arrive while free, so it always wins over the drain transitions.
   always_comb begin
      state_d = state_q;
      zero_d  = zero_q;
      hold_d  = hold_q;
      if (grant_i) begin
         state_d = RSP_LIVE;
         zero_d  = zero_i;
      end else begin
         case (state_q)
            RSP_LIVE: begin
               if (rsp_ready_i) begin
                  state_d = RSP_IDLE;
               end else begin
                  state_d = RSP_HOLD;
                  hold_d  = live_data;
               end
            end
            RSP_HOLD: if (rsp_ready_i) state_d = RSP_IDLE;
            default:  state_d = RSP_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RSP_IDLE;
         zero_q  <= 1'b0;
         hold_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         zero_q  <= zero_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin share of one single-port RAM between ifetch (port 0) and data (port 1); response in T+1,
// a stalled response blocks only its own port. RAM_ARB_ROM_PROTECT_EN rejects data writes below ROM_WORDS.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_BITS = RAM_ARB_ADDR_BITS
`ifdef RAM_ARB_ROM_PROTECT_EN
   ,
   parameter int ROM_WORDS = RAM_ARB_ROM_WORDS
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_cmd_valid,
   output logic                 i_cmd_ready,
   input  logic [ADDR_BITS-1:0] i_cmd_addr,
   output logic                 i_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [31:0]          i_rsp_data,
   input  logic                 d_cmd_valid,
   output logic                 d_cmd_ready,
   input  logic [ADDR_BITS-1:0] d_cmd_addr,
   input  logic                 d_cmd_wr,
   input  logic [3:0]           d_cmd_mask,
   input  logic [31:0]          d_cmd_data,
   output logic                 d_rsp_valid,
   input  logic                 d_rsp_ready,
   output logic [31:0]          d_rsp_data,
   output logic                 d_rsp_err,
   output logic                 ram_en,
   output logic                 ram_wr,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [3:0]           ram_mask,
   output logic [31:0]          ram_wdata,
   input  logic [31:0]          ram_rdata
);

   logic [1:0] rst_sync_q;
   logic       rst_int_n;
   logic       ptr_q, ptr_d;
   logic       free0, free1, elig0, elig1, grant0, grant1;
   logic       rom_reject;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

`ifdef RAM_ARB_ROM_PROTECT_EN
   logic err_q;
   assign rom_reject = d_cmd_wr && (int'(d_cmd_addr) < ROM_WORDS);
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)  err_q <= 1'b0;
      else if (grant1) err_q <= rom_reject;
   end
   assign d_rsp_err = d_rsp_valid & err_q;
`else
   assign rom_reject = 1'b0;
   assign d_rsp_err  = 1'b0;
`endif

   // Gated by the synchronised reset so nothing is granted until the release has propagated.
   assign elig0  = i_cmd_valid & free0;
   assign elig1  = d_cmd_valid & free1;
   assign grant0 = rst_int_n & elig0 & (!elig1 || ptr_q == PORT_IFETCH);
   assign grant1 = rst_int_n & elig1 & (!elig0 || ptr_q == PORT_DATA);

   assign i_cmd_ready = grant0;
   assign d_cmd_ready = grant1;

   always_comb begin
      ptr_d = ptr_q;
      if (grant0)      ptr_d = PORT_DATA;
      else if (grant1) ptr_d = PORT_IFETCH;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) ptr_q <= PORT_IFETCH;
      else            ptr_q <= ptr_d;
   end

   always_comb begin
      ram_en    = 1'b0;
      ram_wr    = 1'b0;
      ram_addr  = '0;
      ram_mask  = 4'h0;
      ram_wdata = 32'h0;
      if (grant0) begin
         ram_en   = 1'b1;
         ram_addr = i_cmd_addr;
         ram_mask = 4'hF;
      end else if (grant1) begin
         ram_en    = 1'b1;
         ram_wr    = d_cmd_wr & ~rom_reject;
         ram_addr  = d_cmd_addr;
         ram_mask  = d_cmd_mask;
         ram_wdata = d_cmd_data;
      end
   end

   ram_arb_rsp_slot u_slot_if (
      .clk         (clk),
      .rst_n       (rst_int_n),
      .grant_i     (grant0),
      .zero_i      (1'b0),
      .rsp_ready_i (i_rsp_ready),
      .ram_rdata_i (ram_rdata),
      .free_o      (free0),
      .rsp_valid_o (i_rsp_valid),
      .rsp_data_o  (i_rsp_data)
   );

   ram_arb_rsp_slot u_slot_d (
      .clk         (clk),
      .rst_n       (rst_int_n),
      .grant_i     (grant1),
      .zero_i      (d_cmd_wr),
      .rsp_ready_i (d_rsp_ready),
      .ram_rdata_i (ram_rdata),
      .free_o      (free1),
      .rsp_valid_o (d_rsp_valid),
      .rsp_data_o  (d_rsp_data)
   );

endmodule
